// File: rtl/alu_pkg.sv
// Shared ALU_control codes, RV32I opcode/funct constants and the request-to-instruction encoder.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_e;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  function automatic enc_t encode(input logic [3:0]  ctrl,
                                  input logic        is_imm,
                                  input logic [4:0]  rd,
                                  input logic [4:0]  rs1,
                                  input logic [4:0]  rs2,
                                  input logic [11:0] imm);
    enc_t        enc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm_f;
    enc       = '0;
    enc.legal = 1'b1;
    f3        = F3_ADD_SUB;
    f7        = F7_BASE;
    imm_f     = imm;
    case (ctrl)
      ALU_ADD:  f3 = F3_ADD_SUB;
      ALU_SUB: begin
        f3 = F3_ADD_SUB;
        f7 = F7_ALT;
        if (is_imm) enc.legal = 1'b0;  // there is no SUBI
      end
      ALU_AND:  f3 = F3_AND;
      ALU_OR:   f3 = F3_OR;
      ALU_XOR:  f3 = F3_XOR;
      ALU_SLL: begin
        f3    = F3_SLL;
        imm_f = {F7_BASE, imm[4:0]};
      end
      ALU_SRL: begin
        f3    = F3_SRL_SRA;
        imm_f = {F7_BASE, imm[4:0]};
      end
      ALU_SRA: begin
        f3    = F3_SRL_SRA;
        f7    = F7_ALT;
        imm_f = {F7_ALT, imm[4:0]};
      end
      ALU_SLT:  f3 = F3_SLT;
      ALU_SLTU: f3 = F3_SLTU;
      default:  enc.legal = 1'b0;
    endcase
    if (!enc.legal) begin
      enc.word = '0;
    end else if (is_imm) begin
      enc.word = {imm_f, rs1, f3, rd, OP_ITYPE};
    end else begin
      enc.word = {f7, rs2, rs1, f3, rd, OP_RTYPE};
    end
    return enc;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags; head word is presented combinationally on o_data.
module sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/alu_instr_encoder.sv
// Encodes ALU requests into RV32I words, buffers them and streams them into instruction memory
// at auto-incrementing, wrapping byte addresses.
module alu_instr_encoder
  import alu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_alu_ctrl,
  input  logic              in_is_imm,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [11:0]       in_imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              err_illegal,
  output logic [15:0]       words_written
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'((IMEM_WORDS - 1) * 4);

  enc_t              w_enc;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [31:0]       w_head;
  logic [ADDR_W-1:0] w_addr_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_last_wdata;
  logic              r_err;
  logic [15:0]       r_count;

  assign w_enc    = encode(in_alu_ctrl, in_is_imm, in_rd, in_rs1, in_rs2, in_imm);
  assign in_ready = !w_full;
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && w_enc.legal;
  assign w_pop    = !w_empty && imem_ready;

  sync_fifo #(
    .Width(32),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_data (w_enc.word),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  // A load wins over the increment; a write on the same edge already used r_addr.
  always_comb begin
    w_addr_nxt = r_addr;
    if (addr_load) begin
      w_addr_nxt = addr_in;
    end else if (w_pop) begin
      w_addr_nxt = (r_addr == LastAddr) ? '0 : r_addr + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_last_wdata <= '0;
      r_err        <= 1'b0;
      r_count      <= '0;
    end else begin
      r_addr <= w_addr_nxt;
      r_err  <= w_accept && !w_enc.legal;
      if (w_pop) begin
        r_last_wdata <= w_head;
        if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
      end
    end
  end

  // With the FIFO empty the data bus keeps showing the last word written.
  assign imem_we       = !w_empty;
  assign imem_wdata    = w_empty ? r_last_wdata : w_head;
  assign imem_addr     = r_addr;
  assign err_illegal   = r_err;
  assign words_written = r_count;

endmodule
